// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter encoding,
// the BTB entry layout and the fall-through PC helper.
// Optional statistics counters are enabled with the BP_STATS_EN macro.
package bp_pkg;

    // Widest address the entry layout can hold; the predictor's XLEN must not exceed it.
    localparam int BP_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    // Tags are stored zero-extended to BP_XLEN so the layout is independent of ENTRIES.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        ctr_t               ctr;
    } bp_entry_t;

    // Next sequential PC after a not-taken branch; wraps modulo 2^BP_XLEN.
    function automatic logic [BP_XLEN-1:0] bp_not_taken_pc(input logic [BP_XLEN-1:0] pc);
        return pc + BP_XLEN'(4);
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    ctr_t ctr_cur;
    ctr_t ctr_nxt;

    assign ctr_cur = ctr_t'(ctr_i);
    assign ctr_o   = ctr_nxt;

    // Step towards the resolved direction, holding at SNT and ST.
    always_comb begin
        ctr_nxt = ctr_cur;
        if (taken_i) begin
            if (ctr_cur != ST) ctr_nxt = ctr_t'(ctr_cur + 2'd1);
        end else begin
            if (ctr_cur != SNT) ctr_nxt = ctr_t'(ctr_cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters beside fetch. Same-cycle prediction
// from table state, training and registered flush/redirect from decode.
// Define BP_STATS_EN to build saturating branch / mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = BP_XLEN,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t table_q [ENTRIES];

    logic            flush_q;
    logic [XLEN-1:0] redirect_q;
    logic [XLEN-1:0] redirect_d;

    logic [IDX_W-1:0]   fetch_idx;
    logic [BP_XLEN-1:0] fetch_tag;
    bp_entry_t          fetch_entry;
    logic               fetch_hit;

    logic [IDX_W-1:0]   upd_idx;
    logic [BP_XLEN-1:0] upd_tag;
    bp_entry_t          upd_entry_q;
    bp_entry_t          upd_entry_d;
    logic               upd_hit;
    logic               upd_write;
    logic [1:0]         upd_ctr_nxt;
    logic               mispred;

    // Byte offset of the fetch PC never reaches the table.
    logic unused_fetch_lsbs;
    assign unused_fetch_lsbs = ^fetch_pc[1:0];

    // Lookup path: purely combinational from the registered table.
    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign fetch_tag   = BP_XLEN'(fetch_pc[XLEN-1:IDX_W+2]);
    assign fetch_entry = table_q[fetch_idx];
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign pred_taken  = fetch_hit && fetch_entry.ctr[1];
    assign pred_target = pred_taken ? XLEN'(fetch_entry.target) : '0;

    // Update path.
    assign upd_idx     = upd_pc[IDX_W+1:2];
    assign upd_tag     = BP_XLEN'(upd_pc[XLEN-1:IDX_W+2]);
    assign upd_entry_q = table_q[upd_idx];
    assign upd_hit     = upd_entry_q.valid && (upd_entry_q.tag == upd_tag);
    assign upd_write   = upd_valid && (upd_hit || upd_taken);

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (upd_entry_q.ctr),
        .taken_i (upd_taken),
        .ctr_o   (upd_ctr_nxt)
    );

    // Build the entry written on an update: train on a hit, allocate on a taken miss.
    always_comb begin
        upd_entry_d = upd_entry_q;
        if (upd_hit) begin
            upd_entry_d.ctr = ctr_t'(upd_ctr_nxt);
            if (upd_taken) upd_entry_d.target = BP_XLEN'(upd_target);
        end else begin
            upd_entry_d.valid  = 1'b1;
            upd_entry_d.tag    = upd_tag;
            upd_entry_d.target = BP_XLEN'(upd_target);
            upd_entry_d.ctr    = CTR_ALLOC;
        end
    end

    // A wrong direction, or a right "taken" with the wrong target, is a mispredict.
    assign mispred = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    assign redirect_d = upd_taken ? upd_target : XLEN'(bp_not_taken_pc(BP_XLEN'(upd_pc)));

    // Table storage; reset only clears valid bits and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= CTR_RESET;
            end
        end else if (upd_write) begin
            table_q[upd_idx] <= upd_entry_d;
        end
    end

    // One-cycle flush pulse per mispredict; redirect holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q <= mispred;
            if (mispred) redirect_q <= redirect_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

`ifdef BP_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (upd_valid && (br_count_q != 32'hFFFF_FFFF)) br_count_q <= br_count_q + 32'd1;
            if (mispred && (mispred_count_q != 32'hFFFF_FFFF)) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`else
    assign br_count      = 32'd0;
    assign mispred_count = 32'd0;
`endif

endmodule
